// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the 7-segment scan logic.
// Holds the scan FSM state enum, segment pattern width and the hex glyph table.
package seg_scan_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;

   localparam int SEG_W = 8;

   // Hex glyphs 0-F, bit order {dp,g,f,e,d,c,b,a}, active-high. Index 15 is listed first.
   localparam logic [15:0][SEG_W-1:0] GLYPH = {
      8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
      8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
   };

   function automatic logic [SEG_W-1:0] glyph(input logic [3:0] v);
      return GLYPH[v];
   endfunction

endpackage

// File: rtl/seg_scan_rr_pick.sv
// seg_scan_rr_pick: combinational round-robin picker.
// next_idx is the first enabled index strictly after cur_idx (modulo DIGITS);
// when cur_idx is the only enabled index it is returned again.
module seg_scan_rr_pick #(
   parameter int DIGITS = 8,
   parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic [DIGITS-1:0] digit_en,
   input  logic [IW-1:0]     cur_idx,
   output logic [IW-1:0]     next_idx,
   output logic              any_en
);

   int j;

   // Walk offsets from farthest to nearest so the nearest enabled index wins.
   always_comb begin
      next_idx = cur_idx;
      any_en   = |digit_en;
      j        = 0;
      for (int k = DIGITS; k >= 1; k--) begin
         j = (int'(cur_idx) + k) % DIGITS;
         if (((digit_en >> j) & DIGITS'(1)) != '0) next_idx = IW'(j);
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-cathode 7-seg bank.
// A free-running slot counter divides time into TICK_DIV-cycle slots; each slot
// starts with BLANK_CYC all-off cycles, then drives one enabled digit.
// Optional macro SCAN_DIM_EN adds a 4-bit brightness input that shortens DRIVE.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int DIGITS    = 8,
   parameter int TICK_DIV  = 62500,
   parameter int BLANK_CYC = 500,
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                    clk50M,
   input  logic                    rst,
   input  logic [DIGITS-1:0]       digit_en,
   input  logic [SEG_W*DIGITS-1:0] seg_data,
`ifdef SCAN_DIM_EN
   input  logic [3:0]              bright,
`endif
   output logic [SEG_W-1:0]        seg_out,
   output logic [DIGITS-1:0]       dig_sel,
   output logic [IW-1:0]           cur_idx,
   output logic                    frame_tick
);

   localparam int CW = $clog2(TICK_DIV);

   if (BLANK_CYC < 1 || BLANK_CYC >= TICK_DIV) begin : g_bad_blank
      $error("seg_scan_ctrl: BLANK_CYC must satisfy 1 <= BLANK_CYC < TICK_DIV");
   end
   if (DIGITS < 2 || DIGITS > 16) begin : g_bad_digits
      $error("seg_scan_ctrl: DIGITS must be in 2..16");
   end

   scan_state_t                   state_q;
   logic [CW-1:0]                 cnt_q;
   logic [IW-1:0]                 cur_q, nxt_idx;
   logic [SEG_W-1:0]              seg_q;
   logic [DIGITS-1:0]             sel_q, lo_mask;
   logic                          ft_q, any_en, bnd, first_d;
   logic [DIGITS-1:0][SEG_W-1:0]  seg_arr;

   assign seg_arr = seg_data;
   assign bnd     = (cnt_q == CW'(TICK_DIV - 1));
   // The new owner opens a frame when no enabled digit sits below it.
   assign lo_mask = (DIGITS'(1) << nxt_idx) - DIGITS'(1);
   assign first_d = any_en && ((digit_en & lo_mask) == '0);

   seg_scan_rr_pick #(.DIGITS(DIGITS), .IW(IW)) u_pick (
      .digit_en (digit_en),
      .cur_idx  (cur_q),
      .next_idx (nxt_idx),
      .any_en   (any_en)
   );

`ifdef SCAN_DIM_EN
   localparam int EW = CW + 1;
   logic [EW-1:0] end_q;
   logic          drv_ok;
   // A dim setting that rounds to zero width never turns the digit on.
   assign drv_ok = (end_q > EW'(BLANK_CYC));
`else
   logic          drv_ok;
   assign drv_ok = 1'b1;
`endif

   // Slot counter: free-runs whenever out of reset, wraps at TICK_DIV-1.
   always_ff @(posedge clk50M or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= bnd ? '0 : cnt_q + CW'(1);
   end

   // Scan FSM with registered outputs; slot boundary overrides every state.
   always_ff @(posedge clk50M or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cur_q   <= IW'(DIGITS - 1);
         seg_q   <= '0;
         sel_q   <= '0;
         ft_q    <= 1'b0;
`ifdef SCAN_DIM_EN
         end_q   <= EW'(TICK_DIV);
`endif
      end else begin
         ft_q <= 1'b0;
         if (bnd) begin
            seg_q <= '0;
            sel_q <= '0;
`ifdef SCAN_DIM_EN
            end_q <= EW'(BLANK_CYC + (((TICK_DIV - BLANK_CYC) * (int'(bright) + 1)) >> 4));
`endif
            if (any_en) begin
               state_q <= BLANK;
               cur_q   <= nxt_idx;
               ft_q    <= first_d;
            end else begin
               state_q <= IDLE;
            end
         end else begin
            case (state_q)
               BLANK: if (cnt_q == CW'(BLANK_CYC - 1)) begin
                  state_q <= DRIVE;
                  if (drv_ok) begin
                     seg_q <= seg_arr[cur_q];
                     sel_q <= DIGITS'(1) << cur_q;
                  end
               end
`ifdef SCAN_DIM_EN
               DRIVE: if ({1'b0, cnt_q} + EW'(1) == end_q) begin
                  seg_q <= '0;
                  sel_q <= '0;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign seg_out    = seg_q;
   assign dig_sel    = sel_q;
   assign cur_idx    = cur_q;
   assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed literal checks plus randomized stimulus compared
// every cycle against a slot-level behavioural model of the scan controller.
module tb_seg_scan_ctrl;

   localparam int D  = 4;
   localparam int TD = 20;
   localparam int BC = 4;

   logic           clk50M   = 1'b0;
   logic           rst      = 1'b0;
   logic [D-1:0]   digit_en = '0;
   logic [8*D-1:0] seg_data = '0;
`ifdef SCAN_DIM_EN
   logic [3:0]     bright   = 4'd15;
`endif
   logic [7:0]     seg_out;
   logic [D-1:0]   dig_sel;
   logic [1:0]     cur_idx;
   logic           frame_tick;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #10 clk50M = ~clk50M;

   seg_scan_ctrl #(.DIGITS(D), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
      .clk50M     (clk50M),
      .rst        (rst),
      .digit_en   (digit_en),
      .seg_data   (seg_data),
`ifdef SCAN_DIM_EN
      .bright     (bright),
`endif
      .seg_out    (seg_out),
      .dig_sel    (dig_sel),
      .cur_idx    (cur_idx),
      .frame_tick (frame_tick)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model: one record per slot ----------------
   int         m_ph, m_own, m_end;
   bit         m_act, m_ft;
   logic [7:0] m_snap;

   function automatic int pick(input int cur, input logic [D-1:0] en);
      for (int k = 1; k <= D; k++)
         if (((en >> ((cur + k) % D)) & 4'd1) != 0) return (cur + k) % D;
      return cur;
   endfunction

   function automatic int lowest(input logic [D-1:0] en);
      for (int i = 0; i < D; i++)
         if (((en >> i) & 4'd1) != 0) return i;
      return -1;
   endfunction

   function automatic int drive_end();
`ifdef SCAN_DIM_EN
      return BC + (((TD - BC) * (int'(bright) + 1)) >> 4);
`else
      return TD;
`endif
   endfunction

   always @(posedge clk50M or negedge rst) begin
      if (!rst) begin
         m_ph <= 0; m_own <= D - 1; m_act <= 1'b0; m_ft <= 1'b0; m_snap <= '0; m_end <= TD;
      end else if (m_ph == TD - 1) begin
         m_ph  <= 0;
         m_act <= (digit_en != '0);
         m_own <= (digit_en != '0) ? pick(m_own, digit_en) : m_own;
         m_ft  <= (digit_en != '0) && (pick(m_own, digit_en) == lowest(digit_en));
         m_end <= drive_end();
      end else begin
         m_ph <= m_ph + 1;
         if (m_ph == BC - 1) m_snap <= 8'(seg_data >> (8 * m_own));
      end
   end

   bit on_exp;
   always @(negedge clk50M) begin
      if (chk_en) begin
         on_exp = m_act && (m_ph >= BC) && (m_ph < m_end);
         chk("model_dig_sel", 32'(dig_sel), on_exp ? 32'(1) << m_own : 32'd0);
         chk("model_seg_out", 32'(seg_out), on_exp ? 32'(m_snap) : 32'd0);
         chk("model_cur_idx", 32'(cur_idx), 32'(m_own));
         chk("model_frame",   32'(frame_tick), 32'(m_ft && (m_ph == 0)));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk50M);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk50M);
      @(negedge clk50M);
      rst = 1'b1;
   endtask

   task automatic wait_ft(input int budget, output int n);
      n = 0;
      while (!frame_tick && n < budget) begin
         tick(1);
         n++;
      end
      chk("ft_wait", 32'(frame_tick), 32'd1);
   endtask

   int n;

   initial begin
      // All digits enabled, canonical pattern
      digit_en = 4'hF;
      seg_data = 32'h5B4F063F;
      do_reset();
      chk_en = 1'b1;
      chk("rst_dig_sel", 32'(dig_sel), 0);
      chk("rst_cur_idx", 32'(cur_idx), 3);
      tick(20);
      chk("s0_frame", 32'(frame_tick), 1);
      chk("s0_cur",   32'(cur_idx), 0);
      chk("s0_blank", 32'(dig_sel), 0);
      tick(4);
      chk("s0_sel", 32'(dig_sel), 4'b0001);
      chk("s0_seg", 32'(seg_out), 8'h3F);
      tick(15);
      chk("s0_hold", 32'(dig_sel), 4'b0001);
      tick(1);
      chk("s1_blank", 32'(dig_sel), 0);
      chk("s1_cur",   32'(cur_idx), 1);
      tick(4);
      chk("s1_seg", 32'(seg_out), 8'h06);
      tick(20);
      chk("s2_seg", 32'(seg_out), 8'h4F);
      tick(20);
      chk("s3_sel", 32'(dig_sel), 4'b1000);
      chk("s3_seg", 32'(seg_out), 8'h5B);
      tick(16);
      chk("wrap_frame", 32'(frame_tick), 1);

      // Mid-slot seg_data change on digit 1 takes effect at its next drive
      tick(30);
      seg_data = {seg_data[31:16], 8'hAA, seg_data[7:0]};
      chk("mid_seg", 32'(seg_out), 8'h06);
      tick(9);
      chk("mid_seg_end", 32'(seg_out), 8'h06);
      tick(65);
      chk("new_seg", 32'(seg_out), 8'hAA);
      chk("new_sel", 32'(dig_sel), 4'b0010);

      // Sparse enable: 0 and 2 alternate, frame every 40 cycles
      digit_en = 4'b0101;
      wait_ft(100, n);
      chk("sparse_cur", 32'(cur_idx), 0);
      tick(1);
      wait_ft(100, n);
      chk("ft_period", 32'(n + 1), 40);

      // Reset pulsed during DRIVE
      tick(6);
      chk("pre_rst_sel", 32'(dig_sel), 4'b0001);
      #2 rst = 1'b0;
      #1;
      chk("async_sel", 32'(dig_sel), 0);
      chk("async_seg", 32'(seg_out), 0);
      chk("async_cur", 32'(cur_idx), 3);
      @(negedge clk50M);
      rst = 1'b1;
      tick(20);
      chk("post_rst_cur", 32'(cur_idx), 0);
      tick(4);
      chk("post_rst_sel", 32'(dig_sel), 4'b0001);
      chk("post_rst_seg", 32'(seg_out), 8'h3F);

      // Nothing enabled from reset, then digit 3 alone mid-slot
      digit_en = '0;
      do_reset();
      tick(45);
      chk("idle_sel", 32'(dig_sel), 0);
      chk("idle_seg", 32'(seg_out), 0);
      digit_en = 4'b1000;
      tick(15);
      chk("solo_cur",   32'(cur_idx), 3);
      chk("solo_frame", 32'(frame_tick), 1);
      tick(4);
      chk("solo_sel", 32'(dig_sel), 4'b1000);
      chk("solo_seg", 32'(seg_out), 8'h5B);
      tick(20);
      chk("solo_again", 32'(dig_sel), 4'b1000);

      // Randomized traffic against the model
      for (int it = 0; it < 3000; it++) begin
         tick(1);
         if ($urandom_range(49) == 0) digit_en = 4'($urandom);
         if ($urandom_range(9) == 0)
            seg_data = seg_data ^ (32'($urandom_range(255)) << (8 * $urandom_range(3)));
`ifdef SCAN_DIM_EN
         if ($urandom_range(29) == 0) bright = 4'($urandom);
`endif
         if ($urandom_range(599) == 0) begin
            #1 rst = 1'b0;
            @(negedge clk50M);
            #1 rst = 1'b1;
         end
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
